// File: rtl/led18_pwm_driver.sv
// LED pin driver behind the 18-bit LED PIO: global PWM dimming, frame-counted blinking and
// output polarity inversion, configured through a 4-register Avalon-MM slave.
module led18_pwm_driver #(
  parameter int unsigned NUM_LEDS   = 18,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam logic [PWM_BITS-1:0] PwmMax = '1;

  logic                  enable_q, blink_en_q, invert_q;
  logic [PWM_BITS-1:0]   duty_req_q, duty_act_q, duty_act_d;
  logic [BLINK_BITS-1:0] half_period_q;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_BITS-1:0] frame_cnt_q, frame_cnt_d, half_eff;
  logic                  blink_phase_q, blink_phase_d;
  logic [NUM_LEDS-1:0]   led_q, led_out_d;
  logic                  wr, wr_ctrl, wr_duty, wr_blink;
  logic                  frame_wrap, pwm_on, gate;
  logic                  unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wr_ctrl      = wr && (address == 2'd0);
  assign wr_duty      = wr && (address == 2'd1);
  assign wr_blink     = wr && (address == 2'd2);
  assign unused_wdata = ^writedata;

  always_comb begin
    frame_wrap    = enable_q && (pwm_cnt_q == PwmMax);
    pwm_cnt_d     = enable_q ? pwm_cnt_q + 1'b1 : '0;
    duty_act_d    = duty_act_q;
    // A DUTY write landing on the wrap cycle is forwarded so the new frame uses it.
    if (!enable_q || frame_wrap) begin
      duty_act_d = wr_duty ? writedata[PWM_BITS-1:0] : duty_req_q;
    end

    half_eff      = (half_period_q == '0) ? BLINK_BITS'(1) : half_period_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wr_blink || !blink_en_q || !enable_q) begin
      frame_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (frame_wrap) begin
      if (frame_cnt_q == half_eff - BLINK_BITS'(1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + BLINK_BITS'(1);
      end
    end

    if (duty_act_q == '0) begin
      pwm_on = 1'b0;
    end else if (duty_act_q == PwmMax) begin
      pwm_on = 1'b1;
    end else begin
      pwm_on = pwm_cnt_q < duty_act_q;
    end
    gate      = enable_q & pwm_on & (~blink_en_q | ~blink_phase_q);
    led_out_d = (led_q & {NUM_LEDS{gate}}) ^ {NUM_LEDS{invert_q}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q      <= 1'b0;
      blink_en_q    <= 1'b0;
      invert_q      <= 1'b0;
      duty_req_q    <= '0;
      half_period_q <= '0;
      duty_act_q    <= '0;
      pwm_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      led_q         <= '0;
      led_out       <= '0;
    end else begin
      if (wr_ctrl) begin
        enable_q   <= writedata[0];
        blink_en_q <= writedata[1];
        invert_q   <= writedata[2];
      end
      if (wr_duty)  duty_req_q    <= writedata[PWM_BITS-1:0];
      if (wr_blink) half_period_q <= writedata[BLINK_BITS-1:0];
      duty_act_q    <= duty_act_d;
      pwm_cnt_q     <= pwm_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_q         <= led_in;
      led_out       <= led_out_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[2:0] = {invert_q, blink_en_q, enable_q};
      2'd1: readdata[PWM_BITS-1:0] = duty_req_q;
      2'd2: readdata[BLINK_BITS-1:0] = half_period_q;
      default: begin
        readdata[8 +: PWM_BITS] = pwm_cnt_q;
        readdata[0]             = blink_phase_q;
      end
    endcase
  end

endmodule
